// File: rtl/mips_pkg.sv
// Shared definitions for the register-file slice.
// Holds the default datapath/address widths and the bulk-clear FSM state type.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

endpackage : mips_pkg

// File: rtl/reg_file_param_clear_fsm.sv
// rf_clear_fsm: sequencer for the register-file bulk clear.
// Walks a pointer over every address, producing one zero-write strobe per cycle.
// Ports:
//   i_clk, i_rst     clock, synchronous active-low reset
//   i_clr_req        clear request, honoured only in IDLE
//   o_busy           high exactly while in CLEAR
//   o_clr_done       one-cycle pulse in DONE
//   o_idle           high in IDLE; gates external writes in the parent
//   o_clr_we         zero-write strobe for the array
//   o_clr_addr       address to zero this cycle
module rf_clear_fsm
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_clr_done,
    output logic              o_idle,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        o_busy      = 1'b0;
        o_clr_done  = 1'b0;
        o_idle      = 1'b0;
        o_clr_we    = 1'b0;
        o_clr_addr  = r_ptr;
        case (r_state)
            ST_IDLE: begin
                o_idle = 1'b1;
                if (i_clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                o_busy   = 1'b1;
                o_clr_we = 1'b1;
                // Last address: stop here instead of incrementing, so ptr never wraps.
                if (r_ptr == '1) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            ST_DONE: begin
                o_clr_done  = 1'b1;
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

endmodule : rf_clear_fsm

// File: rtl/reg_file_param.sv
// reg_file_param: parameterised multi-read, single-write register file with
// byte enables, optional write-to-read bypass, optional hardwired zero r0 and
// a sequenced bulk clear.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   rd_addr/rd_data  NREAD combinational read ports, port k at slice k
//   we/wr_addr/wr_data/wr_be  byte-enabled write port (accepted only in IDLE)
//   clr_req          start a bulk clear
//   busy, clr_done   clear in progress / clear completed pulse
module reg_file_param
    import mips_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NREAD   = 2,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W/8-1:0]     wr_be,
    input  logic                    clr_req,
    output logic                    busy,
    output logic                    clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_idle;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_merged;
    logic [ADDR_W-1:0] w_ra;

    rf_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr_req  (clr_req),
        .o_busy     (busy),
        .o_clr_done (clr_done),
        .o_idle     (w_idle),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Effective write: only in IDLE, and never to r0 when it is hardwired.
    always_comb begin
        w_wr_en = we && w_idle && !((R0_ZERO != 0) && (wr_addr == '0));
    end

    always_comb begin
        w_merged = r_mem[wr_addr];
        for (int unsigned b = 0; b < NBYTE; b++) begin
            if (wr_be[b]) begin
                w_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[wr_addr] <= w_merged;
        end
    end

    // r0 check comes first so a bypassed write can never leak through address 0.
    always_comb begin
        rd_data = '0;
        w_ra    = '0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            w_ra = rd_addr[k*ADDR_W +: ADDR_W];
            if ((R0_ZERO != 0) && (w_ra == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && w_wr_en && (w_ra == wr_addr)) begin
                rd_data[k*DATA_W +: DATA_W] = w_merged;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = r_mem[w_ra];
            end
        end
    end

endmodule : reg_file_param
